// File: rtl/commit_trace_tx.sv
// commit_trace_tx
//   Captures retired instructions into a small commit FIFO and serializes
//   each entry onto a 32-bit valid/ready stream as a 4-word packet:
//   header, PC, instruction word, write data.
//
// Parameters
//   DEPTH   commit-FIFO entries (power of two, >= 2)
//   MARKER  constant placed in header bits [15:0]
//
// Ports
//   clk             single clock, rising edge
//   reset           synchronous, active-high
//   retire_valid    one instruction retired this cycle
//   retire_pc       PC of the retired instruction
//   retire_instr    retired instruction word
//   retire_wr_en    retired instruction writes the register file
//   retire_wr_reg   destination register index
//   retire_wr_data  value written
//   stall_req       FIFO full; core should hold retirement
//   tx_valid        tx_data holds a valid trace word
//   tx_ready        consumer accepts tx_data this cycle
//   tx_data         current trace word
//   overflow        sticky: at least one retirement was dropped
//   drop_cnt        saturating count of dropped retirements

module commit_trace_tx #(
   parameter int unsigned DEPTH  = 4,
   parameter logic [15:0] MARKER = 16'hA5A5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        retire_valid,
   input  logic [31:0] retire_pc,
   input  logic [31:0] retire_instr,
   input  logic        retire_wr_en,
   input  logic [4:0]  retire_wr_reg,
   input  logic [31:0] retire_wr_data,
   output logic        stall_req,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] tx_data,
   output logic        overflow,
   output logic [15:0] drop_cnt
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_PC    = 3'd2;
   localparam logic [2:0] S_INSTR = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;

   typedef struct packed {
      logic [7:0]  seq;
      logic        wr_en;
      logic [4:0]  wr_reg;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] data;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   entry_t        new_entry;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [2:0]    state;
   logic [7:0]    seq;
   logic          full;
   logic          push;
   logic          pop;
   logic          drop;

   assign full      = (count == CW'(DEPTH));
   assign stall_req = full;
   assign head      = mem[rd_ptr];

   // A pop on the DATA transfer frees a slot in the same cycle, so a
   // retirement arriving with the FIFO full is still accepted then.
   assign pop  = (state == S_DATA) && tx_ready;
   assign push = retire_valid && (!full || pop);
   assign drop = retire_valid && full && !pop;

   always_comb begin
      new_entry        = '0;
      new_entry.seq    = seq;
      new_entry.wr_en  = retire_wr_en;
      new_entry.wr_reg = retire_wr_reg;
      new_entry.pc     = retire_pc;
      new_entry.instr  = retire_instr;
      new_entry.data   = retire_wr_en ? retire_wr_data : 32'h0;
   end

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= new_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         seq      <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
         state    <= S_IDLE;
      end else begin
         count <= count_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         // Sequence numbers advance for dropped retirements too, so gaps
         // in the trace reveal where entries were lost.
         if (retire_valid) begin
            seq <= seq + 8'd1;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + 16'd1;
            end
         end
         case (state)
            S_IDLE:  if (count != '0) state <= S_HDR;
            S_HDR:   if (tx_ready) state <= S_PC;
            S_PC:    if (tx_ready) state <= S_INSTR;
            S_INSTR: if (tx_ready) state <= S_DATA;
            // Go straight to the next header when anything remains,
            // including an entry pushed on this same cycle.
            S_DATA:  if (tx_ready) state <= (count_nxt != '0) ? S_HDR : S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      tx_valid = (state != S_IDLE);
      tx_data  = '0;
      case (state)
         S_HDR:   tx_data = {head.seq, head.wr_en, head.wr_reg, 2'b00, MARKER};
         S_PC:    tx_data = head.pc;
         S_INSTR: tx_data = head.instr;
         S_DATA:  tx_data = head.data;
         default: tx_data = '0;
      endcase
   end

endmodule

// File: tb/tb_commit_trace_tx.sv
// tb_commit_trace_tx
//   Directed bench for commit_trace_tx (DEPTH=4, MARKER=16'hA5A5).
//   Header layout used for expected values:
//   {seq[31:24], wr_en[23], wr_reg[22:18], 2'b00[17:16], MARKER[15:0]}.

module tb_commit_trace_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        retire_valid;
   logic [31:0] retire_pc;
   logic [31:0] retire_instr;
   logic        retire_wr_en;
   logic [4:0]  retire_wr_reg;
   logic [31:0] retire_wr_data;
   logic        stall_req;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] tx_data;
   logic        overflow;
   logic [15:0] drop_cnt;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   commit_trace_tx #(.DEPTH(4), .MARKER(16'hA5A5)) dut (
      .clk            (clk),
      .reset          (reset),
      .retire_valid   (retire_valid),
      .retire_pc      (retire_pc),
      .retire_instr   (retire_instr),
      .retire_wr_en   (retire_wr_en),
      .retire_wr_reg  (retire_wr_reg),
      .retire_wr_data (retire_wr_data),
      .stall_req      (stall_req),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .tx_data        (tx_data),
      .overflow       (overflow),
      .drop_cnt       (drop_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_retire(input logic [31:0] pc, input logic [31:0] instr,
                             input logic en, input logic [4:0] rd, input logic [31:0] data);
      retire_valid   = 1'b1;
      retire_pc      = pc;
      retire_instr   = instr;
      retire_wr_en   = en;
      retire_wr_reg  = rd;
      retire_wr_data = data;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      retire_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   logic [7:0]  exp_seq   [4] = '{8'd1, 8'd2, 8'd3, 8'd6};
   logic [31:0] exp_pc    [4] = '{32'h104, 32'h108, 32'h10C, 32'h200};
   logic [31:0] exp_instr [4] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hB000_0006};

   initial begin
      reset          = 1'b1;
      retire_valid   = 1'b0;
      retire_pc      = '0;
      retire_instr   = '0;
      retire_wr_en   = 1'b0;
      retire_wr_reg  = '0;
      retire_wr_data = '0;
      tx_ready       = 1'b1;
      #1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_data", tx_data, 32'd0);
      check("rst_stall", {31'd0, stall_req}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_drop", {16'd0, drop_cnt}, 32'd0);

      // Single writing retire, consumer always ready
      set_retire(32'h0000_0040, 32'h2402_000A, 1'b1, 5'd2, 32'hA);
      tick();                                   // edge E
      retire_valid = 1'b0;
      check("single_e0_valid", {31'd0, tx_valid}, 32'd0);
      tick();                                   // E+1: HDR
      check("single_hdr_valid", {31'd0, tx_valid}, 32'd1);
      check("single_hdr", tx_data, 32'h0088_A5A5); // seq0, en1, reg2
      tick();
      check("single_pc", tx_data, 32'h0000_0040);
      tick();
      check("single_instr", tx_data, 32'h2402_000A);
      tick();
      check("single_data", tx_data, 32'h0000_000A);
      tick();
      check("single_idle", {31'd0, tx_valid}, 32'd0);

      // Non-writing retire then a back-to-back writing retire
      do_reset();
      set_retire(32'h0000_0044, 32'h1000_FFFF, 1'b0, 5'd0, 32'h1234);
      tick();
      set_retire(32'h0000_0048, 32'h0C00_0010, 1'b1, 5'd31, 32'h0000_004C);
      tick();
      retire_valid = 1'b0;
      check("nowr_hdr", tx_data, 32'h0000_A5A5);
      tick();
      check("nowr_pc", tx_data, 32'h0000_0044);
      tick();
      check("nowr_instr", tx_data, 32'h1000_FFFF);
      tick();
      check("nowr_data", tx_data, 32'h0);
      tick();
      check("b2b_valid", {31'd0, tx_valid}, 32'd1);
      check("b2b_hdr", tx_data, 32'h01FC_A5A5);  // seq1, en1, reg31
      tick();
      check("b2b_pc", tx_data, 32'h0000_0048);
      tick();
      check("b2b_instr", tx_data, 32'h0C00_0010);
      tick();
      check("b2b_data", tx_data, 32'h0000_004C);
      tick();
      check("b2b_idle", {31'd0, tx_valid}, 32'd0);

      // Backpressure during the PC word
      do_reset();
      set_retire(32'h0000_0080, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
      tick();
      retire_valid = 1'b0;
      tx_ready     = 1'b0;
      tick();
      check("bp_hdr_hold", tx_data, 32'h0000_A5A5);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check("bp_pc", tx_data, 32'h0000_0080);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("bp_hold_valid%0d", i), {31'd0, tx_valid}, 32'd1);
         check($sformatf("bp_hold_pc%0d", i), tx_data, 32'h0000_0080);
      end
      tx_ready = 1'b1;
      tick();
      check("bp_instr", tx_data, 32'h1234_5678);
      tick();
      check("bp_data", tx_data, 32'h0);
      tick();
      check("bp_idle", {31'd0, tx_valid}, 32'd0);

      // Fill, overflow, then accept on the DATA-transfer pop
      tx_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_retire(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 5'd0, 32'hFFFF);
         tick();
         check($sformatf("fill_stall%0d", i), {31'd0, stall_req}, (i >= 3) ? 32'd1 : 32'd0);
      end
      retire_valid = 1'b0;
      check("fill_ovf", {31'd0, overflow}, 32'd1);
      check("fill_drop", {16'd0, drop_cnt}, 32'd2);
      check("fill_hdr0", tx_data, 32'h0000_A5A5);
      tx_ready = 1'b1;
      tick();
      check("fill_pc0", tx_data, 32'h0000_0100);
      tick();
      check("fill_instr0", tx_data, 32'hA000_0000);
      tick();
      check("fill_data0", tx_data, 32'h0);
      check("fill_full_at_data", {31'd0, stall_req}, 32'd1);
      set_retire(32'h200, 32'hB000_0006, 1'b0, 5'd0, 32'h0);
      tick();
      retire_valid = 1'b0;
      check("popacc_drop", {16'd0, drop_cnt}, 32'd2);
      check("popacc_stall", {31'd0, stall_req}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("drain_hdr%0d", k), tx_data, {exp_seq[k], 8'h00, 16'hA5A5});
         tick();
         check($sformatf("drain_pc%0d", k), tx_data, exp_pc[k]);
         tick();
         check($sformatf("drain_instr%0d", k), tx_data, exp_instr[k]);
         tick();
         check($sformatf("drain_data%0d", k), tx_data, 32'h0);
         tick();
      end
      check("drain_idle", {31'd0, tx_valid}, 32'd0);
      check("drain_stall", {31'd0, stall_req}, 32'd0);
      check("drain_ovf_sticky", {31'd0, overflow}, 32'd1);

      // Reset mid-packet during the INSTR word
      do_reset();
      set_retire(32'h300, 32'h0000_0001, 1'b1, 5'd5, 32'h55);
      tick();
      retire_valid = 1'b0;
      tick();
      tick();
      tick();
      check("mid_instr", tx_data, 32'h0000_0001);
      reset = 1'b1;
      set_retire(32'h999, 32'h999, 1'b1, 5'd7, 32'h999);
      tick();
      reset        = 1'b0;
      retire_valid = 1'b0;
      check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
      check("mid_rst_data", tx_data, 32'd0);
      check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
      check("mid_rst_drop", {16'd0, drop_cnt}, 32'd0);
      tick();
      tick();
      check("mid_rst_quiet", {31'd0, tx_valid}, 32'd0);
      set_retire(32'h304, 32'h0000_0002, 1'b1, 5'd5, 32'h66);
      tick();
      retire_valid = 1'b0;
      tick();
      check("post_rst_hdr", tx_data, 32'h0094_A5A5); // seq0, en1, reg5

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
